// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one single-transaction I2C master between NUM_REQ
// requesters. Requesters are granted round-robin, each transaction is tracked
// through the master's ready level, and the read data and slave-ACK status
// are returned to the granted requester with a one-cycle rsp_valid pulse.
// Optional build macro: I2C_ARB_RETRY_EN adds up to MAX_RETRY automatic
// relaunches of a NACKed transaction before the response is reported.
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int MAX_RETRY      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [16*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [NUM_REQ-1:0]      req_two_bytes,
    output logic [NUM_REQ-1:0]      req_accept,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_rdata,
    output logic                    rsp_ack,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    m_start,
    output logic [6:0]              m_addr,
    output logic [15:0]             m_data,
    output logic                    m_rw,
    output logic                    m_two_bytes,
    input  logic                    m_ready,
    input  logic [15:0]             m_read_data,
    input  logic                    m_got_ack
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

    // Reject configurations the id and timer widths were not sized for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || MAX_RETRY < 0) begin : g_paramCheck
        $error("i2c_txn_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [IDW-1:0]     r_rrPtr;
    logic [IDW-1:0]     r_grantId;
    logic [TW-1:0]      r_timer;
    logic [NUM_REQ-1:0] r_accept;
    logic [NUM_REQ-1:0] r_rspValid;
    logic [15:0]        r_rspRdata;
    logic               r_rspAck;
    logic               r_rspErr;
    logic [6:0]         r_mAddr;
    logic [15:0]        r_mData;
    logic               r_mRw;
    logic               r_mTwoBytes;
    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic               w_timeoutHit;
    logic               w_enterResp;

`ifdef I2C_ARB_RETRY_EN
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTW-1:0]     r_retryCnt;
    logic               w_retry;
`endif

    // Round-robin search: first valid requester at or after r_rrPtr, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rrPtr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    // Next-state logic; the timeout check wins over any master handshake.
    always_comb begin
        w_nextState  = r_state;
        w_timeoutHit = 1'b0;
`ifdef I2C_ARB_RETRY_EN
        w_retry      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nextState = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (r_timer == TIMER_LAST) begin
                    w_nextState  = S_RESP;
                    w_timeoutHit = 1'b1;
                end else if (!m_ready) begin
                    w_nextState = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (r_timer == TIMER_LAST) begin
                    w_nextState  = S_RESP;
                    w_timeoutHit = 1'b1;
                end else if (m_ready) begin
`ifdef I2C_ARB_RETRY_EN
                    if (!m_got_ack && (r_retryCnt < RTW'(MAX_RETRY))) begin
                        w_nextState = S_LAUNCH;
                        w_retry     = 1'b1;
                    end else begin
                        w_nextState = S_RESP;
                    end
`else
                    w_nextState = S_RESP;
`endif
                end
            end
            S_RESP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_enterResp = (w_nextState == S_RESP) && (r_state != S_RESP);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Per-state wait timer: cleared on every state change, counts while waiting on the master.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_nextState != r_state) begin
            r_timer <= '0;
        end else if (r_state == S_LAUNCH || r_state == S_WAIT_DONE) begin
            r_timer <= r_timer + 1'b1;
        end
    end

`ifdef I2C_ARB_RETRY_EN
    // NACK retry counter, restarted for every newly granted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retryCnt <= '0;
        end else if (r_state == S_IDLE && w_found) begin
            r_retryCnt <= '0;
        end else if (w_retry) begin
            r_retryCnt <= r_retryCnt + 1'b1;
        end
    end
`endif

    // Grant capture, accept pulse and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rrPtr     <= '0;
            r_grantId   <= '0;
            r_accept    <= '0;
            r_rspValid  <= '0;
            r_rspRdata  <= '0;
            r_rspAck    <= 1'b0;
            r_rspErr    <= 1'b0;
            r_mAddr     <= '0;
            r_mData     <= '0;
            r_mRw       <= 1'b0;
            r_mTwoBytes <= 1'b0;
        end else begin
            r_accept   <= '0;
            r_rspValid <= '0;
            r_rspRdata <= '0;
            r_rspAck   <= 1'b0;
            r_rspErr   <= 1'b0;
            if (r_state == S_IDLE && w_found) begin
                r_grantId          <= w_winner;
                r_accept[w_winner] <= 1'b1;
                r_mAddr            <= req_addr[int'(w_winner)*7 +: 7];
                r_mData            <= req_data[int'(w_winner)*16 +: 16];
                r_mRw              <= req_rw[w_winner];
                r_mTwoBytes        <= req_two_bytes[w_winner];
                r_rrPtr            <= (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;
            end
            if (w_enterResp) begin
                r_rspValid[r_grantId] <= 1'b1;
                if (w_timeoutHit) begin
                    r_rspErr <= 1'b1;
                end else begin
                    r_rspAck   <= m_got_ack;
                    r_rspRdata <= r_mRw ? m_read_data : 16'h0000;
                end
            end
        end
    end

    assign req_accept  = r_accept;
    assign rsp_valid   = r_rspValid;
    assign rsp_rdata   = r_rspRdata;
    assign rsp_ack     = r_rspAck;
    assign rsp_err     = r_rspErr;
    assign busy        = (r_state != S_IDLE);
    assign m_start     = (r_state == S_LAUNCH);
    assign m_addr      = r_mAddr;
    assign m_data      = r_mData;
    assign m_rw        = r_mRw;
    assign m_two_bytes = r_mTwoBytes;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed testbench for i2c_txn_arbiter with a behavioural I2C master model.
// Expected values are hand-computed per scenario; honours I2C_ARB_RETRY_EN.
module tb_i2c_txn_arbiter;

    localparam int NREQ = 4;
    localparam int TOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [7*NREQ-1:0] req_addr = '0;
    logic [16*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [NREQ-1:0]   req_two_bytes = '0;
    logic [NREQ-1:0]   req_accept;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              rsp_ack;
    logic              rsp_err;
    logic              busy;
    logic              m_start;
    logic [6:0]        m_addr;
    logic [15:0]       m_data;
    logic              m_rw;
    logic              m_two_bytes;
    logic              m_ready;
    logic [15:0]       m_read_data;
    logic              m_got_ack;

    int          checkCount = 0;
    int          passCount  = 0;
    int          modelDur   = 3;
    logic        modelAck   = 1'b1;
    logic [15:0] modelRdata = 16'h0000;
    logic        modelStuck = 1'b0;
    int          startCount = 0;
    int          modelCnt;

    logic [52:0] allOutputs;
    assign allOutputs = {req_accept, rsp_valid, rsp_rdata, rsp_ack, rsp_err, busy,
                         m_start, m_addr, m_data, m_rw, m_two_bytes};

    i2c_txn_arbiter #(
        .NUM_REQ(NREQ),
        .TIMEOUT_CYCLES(TOUT),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_rw(req_rw),
        .req_two_bytes(req_two_bytes),
        .req_accept(req_accept),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_ack(rsp_ack),
        .rsp_err(rsp_err),
        .busy(busy),
        .m_start(m_start),
        .m_addr(m_addr),
        .m_data(m_data),
        .m_rw(m_rw),
        .m_two_bytes(m_two_bytes),
        .m_ready(m_ready),
        .m_read_data(m_read_data),
        .m_got_ack(m_got_ack)
    );

    always #5 clk = ~clk;

    // Master model: takes a start while ready, stays busy modelDur+1 cycles, then reports.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready     <= 1'b1;
            modelCnt    <= 0;
            m_read_data <= 16'h0000;
            m_got_ack   <= 1'b0;
        end else if (m_ready && m_start && !modelStuck) begin
            m_ready    <= 1'b0;
            modelCnt   <= modelDur;
            startCount <= startCount + 1;
        end else if (!m_ready) begin
            if (modelCnt == 0) begin
                m_ready     <= 1'b1;
                m_read_data <= modelRdata;
                m_got_ack   <= modelAck;
            end else begin
                modelCnt <= modelCnt - 1;
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic [6:0] a, input logic [15:0] d,
                                 input logic rw, input logic two);
        req_addr[idx*7 +: 7]   = a;
        req_data[idx*16 +: 16] = d;
        req_rw[idx]            = rw;
        req_two_bytes[idx]     = two;
    endtask

    task automatic waitForAccept(output logic found, output logic [NREQ-1:0] acc, output int cycles);
        found  = 1'b0;
        acc    = '0;
        cycles = 0;
        while (!found && cycles < 64) begin
            @(negedge clk);
            cycles++;
            if (req_accept != '0) begin
                found = 1'b1;
                acc   = req_accept;
            end
        end
    endtask

    task automatic waitForRsp(output logic found, output logic [NREQ-1:0] vld, output logic [15:0] rdata,
                              output logic ack, output logic err, output int cycles);
        found  = 1'b0;
        vld    = '0;
        rdata  = '0;
        ack    = 1'b0;
        err    = 1'b0;
        cycles = 0;
        while (!found && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid != '0) begin
                found = 1'b1;
                vld   = rsp_valid;
                rdata = rsp_rdata;
                ack   = rsp_ack;
                err   = rsp_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(0, 7'h11, 16'h1111, 1'b0, 1'b0);
        req_valid = '1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (allOutputs !== 53'h0) $display("[TB] FAIL reset_outputs: got %h expected 0", allOutputs);
        else passCount++;
        req_valid = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkCount++;
        if ({busy, req_accept} !== 5'b0) $display("[TB] FAIL idle_after_reset: got %b expected 00000", {busy, req_accept});
        else passCount++;
    endtask

    task automatic test_single_write();
        logic found; logic [NREQ-1:0] acc; logic [15:0] rd; logic ack, err; int cyc;
        modelAck = 1'b1; modelRdata = 16'hBEEF; modelDur = 3;
        applyStimulus(0, 7'h48, 16'hA55A, 1'b0, 1'b1);
        req_valid[0] = 1'b1;
        waitForAccept(found, acc, cyc);
        req_valid[0] = 1'b0;
        checkCount++;
        if (acc !== 4'b0001) $display("[TB] FAIL write_accept: got %b expected 0001", acc);
        else passCount++;
        checkCount++;
        if ({busy, m_start, m_addr, m_data, m_rw, m_two_bytes} !== {1'b1, 1'b1, 7'h48, 16'hA55A, 1'b0, 1'b1})
            $display("[TB] FAIL write_launch: got %b %b %h %h %b %b expected 1 1 48 a55a 0 1",
                     busy, m_start, m_addr, m_data, m_rw, m_two_bytes);
        else passCount++;
        waitForRsp(found, acc, rd, ack, err, cyc);
        checkCount++;
        if (acc !== 4'b0001) $display("[TB] FAIL write_rsp_valid: got %b expected 0001", acc);
        else passCount++;
        checkCount++;
        if ({rd, ack, err} !== {16'h0000, 1'b1, 1'b0})
            $display("[TB] FAIL write_rsp_fields: got rdata %h ack %b err %b expected 0000 1 0", rd, ack, err);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({busy, rsp_valid} !== 5'b0) $display("[TB] FAIL write_idle_after: got %b expected 00000", {busy, rsp_valid});
        else passCount++;
    endtask

    task automatic test_read();
        logic found; logic [NREQ-1:0] acc; logic [15:0] rd; logic ack, err; int cyc;
        modelAck = 1'b1; modelRdata = 16'h00C3; modelDur = 4;
        applyStimulus(2, 7'h1D, 16'h1234, 1'b1, 1'b0);
        req_valid[2] = 1'b1;
        waitForAccept(found, acc, cyc);
        req_valid[2] = 1'b0;
        checkCount++;
        if (acc !== 4'b0100) $display("[TB] FAIL read_accept: got %b expected 0100", acc);
        else passCount++;
        checkCount++;
        if ({m_addr, m_rw, m_two_bytes} !== {7'h1D, 1'b1, 1'b0})
            $display("[TB] FAIL read_launch: got %h %b %b expected 1d 1 0", m_addr, m_rw, m_two_bytes);
        else passCount++;
        waitForRsp(found, acc, rd, ack, err, cyc);
        checkCount++;
        if (acc !== 4'b0100) $display("[TB] FAIL read_rsp_valid: got %b expected 0100", acc);
        else passCount++;
        checkCount++;
        if ({rd, ack, err} !== {16'h00C3, 1'b1, 1'b0})
            $display("[TB] FAIL read_rsp_fields: got rdata %h ack %b err %b expected 00c3 1 0", rd, ack, err);
        else passCount++;
    endtask

    task automatic test_timeout();
        logic found; logic [NREQ-1:0] acc; logic [15:0] rd; logic ack, err; int cyc;
        modelStuck = 1'b1; modelRdata = 16'h5A5A;
        applyStimulus(3, 7'h2E, 16'h0000, 1'b1, 1'b1);
        req_valid[3] = 1'b1;
        waitForAccept(found, acc, cyc);
        req_valid[3] = 1'b0;
        checkCount++;
        if (acc !== 4'b1000) $display("[TB] FAIL timeout_accept: got %b expected 1000", acc);
        else passCount++;
        waitForRsp(found, acc, rd, ack, err, cyc);
        checkCount++;
        if (cyc !== TOUT) $display("[TB] FAIL timeout_latency: got %0d expected %0d", cyc, TOUT);
        else passCount++;
        checkCount++;
        if ({acc, rd, ack, err} !== {4'b1000, 16'h0000, 1'b0, 1'b1})
            $display("[TB] FAIL timeout_rsp: got vld %b rdata %h ack %b err %b expected 1000 0000 0 1", acc, rd, ack, err);
        else passCount++;
        checkCount++;
        if ({m_start, busy} !== 2'b01) $display("[TB] FAIL timeout_start_busy: got %b expected 01", {m_start, busy});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL timeout_busy_fall: got %b expected 0", busy);
        else passCount++;
        modelStuck = 1'b0;
    endtask

    task automatic test_nack();
        logic found; logic [NREQ-1:0] acc; logic [15:0] rd; logic ack, err; int cyc; int s0; int expStarts;
`ifdef I2C_ARB_RETRY_EN
        expStarts = 3;
`else
        expStarts = 1;
`endif
        modelAck = 1'b0; modelRdata = 16'h7777; modelDur = 2;
        applyStimulus(1, 7'h22, 16'h00FF, 1'b0, 1'b0);
        s0 = startCount;
        req_valid[1] = 1'b1;
        waitForAccept(found, acc, cyc);
        req_valid[1] = 1'b0;
        checkCount++;
        if (acc !== 4'b0010) $display("[TB] FAIL nack_accept: got %b expected 0010", acc);
        else passCount++;
        waitForRsp(found, acc, rd, ack, err, cyc);
        checkCount++;
        if ({acc, rd, ack, err} !== {4'b0010, 16'h0000, 1'b0, 1'b0})
            $display("[TB] FAIL nack_rsp: got vld %b rdata %h ack %b err %b expected 0010 0000 0 0", acc, rd, ack, err);
        else passCount++;
        checkCount++;
        if ((startCount - s0) !== expStarts)
            $display("[TB] FAIL nack_starts: got %0d expected %0d", startCount - s0, expStarts);
        else passCount++;
        modelAck = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic found; logic [NREQ-1:0] acc; logic [15:0] rd; logic ack, err; int cyc;
        logic [NREQ-1:0] expOne;
        int expId;
        @(negedge clk);
        rst = 1'b0;
        modelAck = 1'b1; modelDur = 1;
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 7'(7'h10 + i), 16'(16'h0100 * i), 1'b0, 1'b1);
        end
        req_valid = '1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            expId  = n % NREQ;
            expOne = 4'b0001 << expId;
            waitForAccept(found, acc, cyc);
            checkCount++;
            if (acc !== expOne) $display("[TB] FAIL rr_accept_%0d: got %b expected %b", n, acc, expOne);
            else passCount++;
            if (n > 0) begin
                checkCount++;
                if (cyc !== 2) $display("[TB] FAIL rr_spacing_%0d: got %0d expected 2", n, cyc);
                else passCount++;
            end
            checkCount++;
            if (m_addr !== 7'(7'h10 + expId)) $display("[TB] FAIL rr_addr_%0d: got %h expected %h", n, m_addr, 7'(7'h10 + expId));
            else passCount++;
            if (n == 4) req_valid = '0;
            waitForRsp(found, acc, rd, ack, err, cyc);
            checkCount++;
            if (acc !== expOne) $display("[TB] FAIL rr_rsp_%0d: got %b expected %b", n, acc, expOne);
            else passCount++;
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic found; logic [NREQ-1:0] acc; logic [15:0] rd; logic ack, err; int cyc;
        modelAck = 1'b1; modelDur = 10;
        applyStimulus(0, 7'h33, 16'hC0DE, 1'b0, 1'b1);
        req_valid[0] = 1'b1;
        waitForAccept(found, acc, cyc);
        req_valid[0] = 1'b0;
        checkCount++;
        if (acc !== 4'b0001) $display("[TB] FAIL async_pre_accept: got %b expected 0001", acc);
        else passCount++;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({busy, m_start} !== 2'b10) $display("[TB] FAIL async_in_wait: got %b expected 10", {busy, m_start});
        else passCount++;
        #2;
        rst = 1'b0;
        #1;
        checkCount++;
        if (allOutputs !== 53'h0) $display("[TB] FAIL async_outputs_zero: got %h expected 0", allOutputs);
        else passCount++;
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 7'(7'h40 + i), 16'h0, 1'b0, 1'b0);
        end
        req_valid = '1;
        repeat (2) @(negedge clk);
        checkCount++;
        if (allOutputs !== 53'h0) $display("[TB] FAIL async_hold: got %h expected 0", allOutputs);
        else passCount++;
        rst = 1'b1;
        waitForAccept(found, acc, cyc);
        req_valid = '0;
        checkCount++;
        if (acc !== 4'b0001) $display("[TB] FAIL async_first_grant: got %b expected 0001", acc);
        else passCount++;
        waitForRsp(found, acc, rd, ack, err, cyc);
        checkCount++;
        if ({acc, ack, err} !== {4'b0001, 1'b1, 1'b0})
            $display("[TB] FAIL async_post_rsp: got vld %b ack %b err %b expected 0001 1 0", acc, ack, err);
        else passCount++;
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_timeout();
        test_nack();
        test_round_robin();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
